// File: rtl/mac_tx_framer.sv
// Store-and-forward TX framer: buffers whole frames, then bursts them to the MAC.
// Pads short frames, enforces the inter-frame gap, drops bad or oversize frames.
//
// Ports:
//   mac_tx_clk, mac_tx_rstn     : clock, async active-low reset
//   s_axis_tdata/tvalid/tlast   : input byte stream
//   s_axis_tuser                : frame error flag, sampled with tlast
//   s_axis_tready               : low only when the buffer is full
//   mac_tx_data/valid/sof/eof   : contiguous frame burst to the MAC
//   stat_tx_frames              : frames emitted (wrapping)
//   stat_drop_frames            : frames dropped (wrapping)
//   busy                        : buffer non-empty or transmit/gap active
module mac_tx_framer #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 1514,
    parameter int MIN_LEN = 60,
    parameter int IFG     = 12
) (
    input  logic        mac_tx_clk,
    input  logic        mac_tx_rstn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_valid,
    output logic        mac_tx_sof,
    output logic        mac_tx_eof,
    output logic [15:0] stat_tx_frames,
    output logic [15:0] stat_drop_frames,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] ptr_t;

    localparam ptr_t        MAX_L    = ptr_t'(MAX_LEN);
    localparam ptr_t        MIN_L    = ptr_t'(MIN_LEN);
    localparam logic [15:0] IFG_LOAD = 16'(IFG - 1);
    localparam bit          ONE_OK   = (MIN_LEN <= 1);

    typedef enum logic {
        WR,
        DISCARD
    } wr_st_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_PAD,
        S_GAP
    } rd_st_t;

    // {last, data}
    logic [8:0] mem [DEPTH];

    wr_st_t      wr_st;
    ptr_t        wr_ptr;
    ptr_t        wr_commit;
    ptr_t        wr_len;
    ptr_t        wr_nxt;
    logic        accept;
    logic        over;
    logic        wr_en;
    logic        commit;

    rd_st_t      rd_st;
    ptr_t        rd_ptr;
    ptr_t        byte_cnt;
    ptr_t        cnt_inc;
    logic        eof_ok;
    logic        last_q;
    logic [15:0] ifg_cnt;
    ptr_t        frame_cnt;

    assign wr_nxt = wr_ptr + 1'b1;

    assign s_axis_tready = !(wr_st == WR && wr_nxt == rd_ptr);

    assign accept = s_axis_tvalid && s_axis_tready;
    // the accepted byte would push the frame past MAX_LEN
    assign over   = (wr_len == MAX_L);
    assign wr_en  = accept && (wr_st == WR) && !over;
    assign commit = wr_en && s_axis_tlast && !s_axis_tuser;

    assign busy = (wr_ptr != rd_ptr) || (rd_st != S_IDLE);

    always_ff @(posedge mac_tx_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge mac_tx_clk or negedge mac_tx_rstn) begin
        if (!mac_tx_rstn) begin
            wr_st            <= WR;
            wr_ptr           <= '0;
            wr_commit        <= '0;
            wr_len           <= '0;
            stat_drop_frames <= '0;
        end else if (accept) begin
            unique case (wr_st)
                WR: begin
                    if (over) begin
                        wr_ptr <= wr_commit;
                        wr_len <= '0;
                        if (s_axis_tlast) begin
                            stat_drop_frames <= stat_drop_frames + 1'b1;
                        end else begin
                            wr_st <= DISCARD;
                        end
                    end else if (s_axis_tlast) begin
                        wr_len <= '0;
                        if (s_axis_tuser) begin
                            wr_ptr           <= wr_commit;
                            stat_drop_frames <= stat_drop_frames + 1'b1;
                        end else begin
                            wr_ptr    <= wr_nxt;
                            wr_commit <= wr_nxt;
                        end
                    end else begin
                        wr_ptr <= wr_nxt;
                        wr_len <= wr_len + 1'b1;
                    end
                end
                DISCARD: begin
                    if (s_axis_tlast) begin
                        stat_drop_frames <= stat_drop_frames + 1'b1;
                        wr_st            <= WR;
                    end
                end
                default: wr_st <= WR;
            endcase
        end
    end

    // committed frames not yet finished; released in the eof cycle
    always_ff @(posedge mac_tx_clk or negedge mac_tx_rstn) begin
        if (!mac_tx_rstn) begin
            frame_cnt <= '0;
        end else begin
            unique case ({commit, mac_tx_eof})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    assign cnt_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
    assign eof_ok  = (cnt_inc >= MIN_L);

    // The RAM read register doubles as the output register, so the byte,
    // its last flag and the eof decision all land on the same edge.
    always_ff @(posedge mac_tx_clk or negedge mac_tx_rstn) begin
        if (!mac_tx_rstn) begin
            rd_st          <= S_IDLE;
            rd_ptr         <= '0;
            byte_cnt       <= '0;
            last_q         <= 1'b0;
            ifg_cnt        <= '0;
            mac_tx_data    <= '0;
            mac_tx_valid   <= 1'b0;
            mac_tx_sof     <= 1'b0;
            mac_tx_eof     <= 1'b0;
            stat_tx_frames <= '0;
        end else begin
            mac_tx_sof <= 1'b0;
            if (mac_tx_eof) begin
                stat_tx_frames <= stat_tx_frames + 1'b1;
            end
            unique case (rd_st)
                S_IDLE: begin
                    if (frame_cnt != '0) begin
                        mac_tx_data  <= mem[rd_ptr][7:0];
                        last_q       <= mem[rd_ptr][8];
                        mac_tx_eof   <= mem[rd_ptr][8] && ONE_OK;
                        mac_tx_valid <= 1'b1;
                        mac_tx_sof   <= 1'b1;
                        byte_cnt     <= ptr_t'(1);
                        rd_ptr       <= rd_ptr + 1'b1;
                        rd_st        <= S_SEND;
                    end
                end
                S_SEND, S_PAD: begin
                    if (mac_tx_eof) begin
                        mac_tx_data  <= '0;
                        mac_tx_valid <= 1'b0;
                        mac_tx_eof   <= 1'b0;
                        last_q       <= 1'b0;
                        ifg_cnt      <= IFG_LOAD;
                        rd_st        <= S_GAP;
                    end else if (!last_q) begin
                        mac_tx_data <= mem[rd_ptr][7:0];
                        last_q      <= mem[rd_ptr][8];
                        mac_tx_eof  <= mem[rd_ptr][8] && eof_ok;
                        byte_cnt    <= cnt_inc;
                        rd_ptr      <= rd_ptr + 1'b1;
                    end else begin
                        mac_tx_data <= '0;
                        mac_tx_eof  <= eof_ok;
                        byte_cnt    <= cnt_inc;
                        rd_st       <= S_PAD;
                    end
                end
                S_GAP: begin
                    // IDLE supplies the last gap cycle before the next sof
                    if (ifg_cnt <= 16'd1) begin
                        rd_st <= S_IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - 1'b1;
                    end
                end
                default: rd_st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Randomized bench for mac_tx_framer.
// Frame-level reference model with output capture and stream compare.
module tb_mac_tx_framer;

    localparam int MAX_LEN = 1514;
    localparam int MIN_LEN = 60;
    localparam int IFG     = 12;

    logic        clk;
    logic        rstn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        s_axis_tready;
    logic [7:0]  mac_tx_data;
    logic        mac_tx_valid;
    logic        mac_tx_sof;
    logic        mac_tx_eof;
    logic [15:0] stat_tx_frames;
    logic [15:0] stat_drop_frames;
    logic        busy;

    mac_tx_framer dut (
        .mac_tx_clk       (clk),
        .mac_tx_rstn      (rstn),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tready    (s_axis_tready),
        .mac_tx_data      (mac_tx_data),
        .mac_tx_valid     (mac_tx_valid),
        .mac_tx_sof       (mac_tx_sof),
        .mac_tx_eof       (mac_tx_eof),
        .stat_tx_frames   (stat_tx_frames),
        .stat_drop_frames (stat_drop_frames),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [7:0] exp_bytes[$];
    int         exp_lens[$];
    int         m_tx = 0;
    int         m_drop = 0;

    // captured output
    logic [7:0] got_bytes[$];
    int         got_lens[$];
    logic [7:0] cur_q[$];
    bit         in_frm = 0;
    bit         have_eof = 0;
    int         eof_cyc = 0;
    int         sof_cyc = 0;
    int         last_gap = 0;
    int         tlast_cyc = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            cur_q.delete();
            in_frm   = 0;
            have_eof = 0;
        end else if (mac_tx_valid) begin
            if (mac_tx_sof) begin
                chk("sof_mid_frame", {31'd0, in_frm}, 0);
                if (have_eof) begin
                    last_gap = cyc - eof_cyc - 1;
                    chk("ifg_min", {31'd0, last_gap >= IFG}, 1);
                end
                sof_cyc = cyc;
                in_frm  = 1;
                cur_q.delete();
            end else begin
                chk("valid_no_sof", {31'd0, in_frm}, 1);
            end
            cur_q.push_back(mac_tx_data);
            if (mac_tx_eof) begin
                foreach (cur_q[i]) got_bytes.push_back(cur_q[i]);
                got_lens.push_back(cur_q.size());
                cur_q.delete();
                in_frm   = 0;
                eof_cyc  = cyc;
                have_eof = 1;
            end
        end else begin
            chk("idle_data", {24'd0, mac_tx_data}, 0);
            chk("idle_ctl", {30'd0, mac_tx_sof, mac_tx_eof}, 0);
            chk("frame_gap", {31'd0, in_frm}, 0);
            in_frm = 0;
            cur_q.delete();
        end
    end

    task automatic send_frame(input int len, input bit bad, input int stall,
                              input bit rnd, input logic [7:0] base,
                              output int nstall);
        logic [7:0] b;
        logic [7:0] fb[$];
        int         w;
        nstall = 0;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            if (stall > 0 && $urandom_range(99) < stall) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                s_axis_tuser  = 1'b0;
                @(posedge clk);
                #1;
            end
            s_axis_tdata  = b;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == len - 1);
            s_axis_tuser  = bad && (i == len - 1);
            w = 0;
            while (!s_axis_tready && w < 4000) begin
                nstall++;
                w++;
                @(posedge clk);
                #1;
            end
            if (!s_axis_tready) begin
                chk("tready_wait", {31'd0, s_axis_tready}, 1);
                break;
            end
            if (i == len - 1) tlast_cyc = cyc;
            @(posedge clk);
            #1;
            fb.push_back(b);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (bad || len > MAX_LEN) begin
            m_drop++;
        end else begin
            m_tx++;
            foreach (fb[i]) exp_bytes.push_back(fb[i]);
            for (int i = len; i < MIN_LEN; i++) exp_bytes.push_back(8'h00);
            exp_lens.push_back(len < MIN_LEN ? MIN_LEN : len);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_busy", {31'd0, busy}, 0);
    endtask

    task automatic flush_cmp(input string tag);
        int         gl;
        int         el;
        int         nb;
        logic [7:0] g;
        logic [7:0] e;
        chk({tag, "_frames"}, got_lens.size(), exp_lens.size());
        while (got_lens.size() > 0 && exp_lens.size() > 0) begin
            gl = got_lens.pop_front();
            el = exp_lens.pop_front();
            nb = 0;
            chk({tag, "_len"}, gl, el);
            for (int i = 0; i < gl; i++) begin
                g = got_bytes.pop_front();
                if (i < el && g !== exp_bytes[i]) nb++;
            end
            for (int i = 0; i < el; i++) e = exp_bytes.pop_front();
            chk({tag, "_data_errs"}, nb, 0);
        end
        got_lens.delete();
        got_bytes.delete();
        exp_lens.delete();
        exp_bytes.delete();
        chk({tag, "_stat_tx"}, {16'd0, stat_tx_frames}, 32'(m_tx));
        chk({tag, "_stat_drop"}, {16'd0, stat_drop_frames}, 32'(m_drop));
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: time limit hit before summary");
        $fatal(1);
    end

    initial begin
        int ns;
        int n;
        int bnd[6];
        bnd = '{1, 59, 60, 61, 1514, 1515};
        rstn          = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, mac_tx_valid}, 0);
        chk("rst_data", {24'd0, mac_tx_data}, 0);
        chk("rst_sofeof", {30'd0, mac_tx_sof, mac_tx_eof}, 0);
        chk("rst_tready", {31'd0, s_axis_tready}, 1);
        chk("rst_stats", {stat_tx_frames, stat_drop_frames}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send_frame(64, 0, 0, 0, 8'h00, ns);
        drain();
        chk("sof_latency", sof_cyc - tlast_cyc, 2);
        flush_cmp("t64");

        send_frame(10, 0, 0, 0, 8'hA0, ns);
        drain();
        flush_cmp("pad10");

        send_frame(100, 0, 0, 1, 8'h00, ns);
        send_frame(100, 0, 0, 1, 8'h00, ns);
        drain();
        chk("b2b_gap", last_gap, IFG);
        flush_cmp("b2b");

        send_frame(40, 1, 0, 1, 8'h00, ns);
        send_frame(60, 0, 0, 1, 8'h00, ns);
        drain();
        flush_cmp("bad");

        send_frame(1600, 0, 0, 1, 8'h00, ns);
        chk("ovs_tready_stalls", ns, 0);
        send_frame(64, 0, 0, 0, 8'h40, ns);
        drain();
        flush_cmp("ovs");

        foreach (bnd[i]) send_frame(bnd[i], 0, 0, 1, 8'h00, ns);
        drain();
        flush_cmp("bound");

        for (int k = 0; k < 12; k++) begin
            send_frame($urandom_range(300, 1), $urandom_range(9) == 0,
                       $urandom_range(60, 0), 1, 8'h00, ns);
        end
        drain();
        flush_cmp("rand");

        send_frame(200, 0, 50, 0, 8'h10, ns);
        n = 0;
        while (cur_q.size() < 50 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte50", {31'd0, cur_q.size() >= 50}, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, mac_tx_valid}, 0);
        chk("arst_data", {24'd0, mac_tx_data}, 0);
        chk("arst_sofeof", {30'd0, mac_tx_sof, mac_tx_eof}, 0);
        chk("arst_tready", {31'd0, s_axis_tready}, 1);
        chk("arst_stats", {stat_tx_frames, stat_drop_frames}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        exp_bytes.delete();
        exp_lens.delete();
        m_tx   = 0;
        m_drop = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(64, 0, 0, 0, 8'h80, ns);
        drain();
        flush_cmp("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
